// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: a 32-cycle iterative shift-add multiplier and restoring divider.
// Latency is fixed at 33 cycles from acceptance to done for every funct3.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_result;
    logic [63:0] r_acc;
    logic [31:0] r_opb;
    logic        r_is_mul;
    logic        r_neg;
    logic        r_sel_hi;
    logic        r_special;
    logic [31:0] r_special_val;

    logic        w_sa;
    logic        w_sb;
    logic        w_sel_hi;
    logic        w_neg;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic        w_div_zero;
    logic        w_ovf;
    logic [31:0] w_special_val;
    logic        w_accept;
    logic        w_step;
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_nx;
    logic [32:0] w_div_sh;
    logic [31:0] w_div_sub;
    logic [63:0] w_div_nx;
    logic [63:0] w_acc_nx;
    logic [63:0] w_neg64;
    logic [31:0] w_pick;
    logic [31:0] w_final;

    // Operand decode at acceptance: signedness, magnitudes, result selection and special cases
    always_comb begin
        w_sa     = 1'b0;
        w_sb     = 1'b0;
        w_sel_hi = 1'b0;
        case (funct3)
            3'b000: w_sel_hi = 1'b0;
            3'b001: begin w_sa = op_a[31]; w_sb = op_b[31]; w_sel_hi = 1'b1; end
            3'b010: begin w_sa = op_a[31]; w_sel_hi = 1'b1; end
            3'b011: w_sel_hi = 1'b1;
            3'b100: begin w_sa = op_a[31]; w_sb = op_b[31]; end
            3'b101: w_sel_hi = 1'b0;
            3'b110: begin w_sa = op_a[31]; w_sb = op_b[31]; w_sel_hi = 1'b1; end
            3'b111: w_sel_hi = 1'b1;
            default: w_sel_hi = 1'b0;
        endcase
        w_mag_a    = w_sa ? (32'd0 - op_a) : op_a;
        w_mag_b    = w_sb ? (32'd0 - op_b) : op_b;
        // Remainder follows the dividend sign; products and quotients follow the sign XOR
        w_neg      = (funct3 == 3'b110) ? w_sa : (w_sa ^ w_sb);
        w_div_zero = funct3[2] && (op_b == 32'd0);
        w_ovf      = funct3[2] && !funct3[0] && (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);
        w_special_val = w_div_zero ? (funct3[1] ? op_a : 32'hFFFF_FFFF)
                                   : (funct3[1] ? 32'd0 : 32'h8000_0000);
    end

    // One iteration of the shift-add multiply or restoring divide, plus final sign fix-up
    always_comb begin
        w_mul_sum = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opb} : 33'd0);
        w_mul_nx  = {w_mul_sum, r_acc[31:1]};
        w_div_sh  = {r_acc[63:32], r_acc[31]};
        w_div_sub = w_div_sh[31:0] - r_opb;
        w_div_nx  = (w_div_sh >= {1'b0, r_opb}) ? {w_div_sub, r_acc[30:0], 1'b1}
                                                : {w_div_sh[31:0], r_acc[30:0], 1'b0};
        w_acc_nx  = r_is_mul ? w_mul_nx : w_div_nx;
        w_neg64   = 64'd0 - w_acc_nx;
        w_pick    = r_sel_hi ? w_acc_nx[63:32] : w_acc_nx[31:0];
        w_final   = w_pick;
        if (r_special) begin
            w_final = r_special_val;
        end else if (r_is_mul && r_neg) begin
            w_final = r_sel_hi ? w_neg64[63:32] : w_neg64[31:0];
        end else if (r_neg) begin
            w_final = 32'd0 - w_pick;
        end else begin
            w_final = w_pick;
        end
    end

    assign w_accept = start && !flush && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_step   = (r_state == S_BUSY) && !flush;

    // Control FSM with registered busy/done and the architectural result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= 5'd0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= 32'd0;
        end else if (flush) begin
            r_state <= S_IDLE;
            r_cnt   <= 5'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    r_cnt  <= 5'd0;
                    if (start) begin
                        r_state <= S_BUSY;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_state  <= S_DONE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_result <= w_final;
                    end else begin
                        r_state <= S_BUSY;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 5'd0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Datapath: operands are captured only on acceptance and iterated only while BUSY
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc         <= 64'd0;
            r_opb         <= 32'd0;
            r_is_mul      <= 1'b0;
            r_neg         <= 1'b0;
            r_sel_hi      <= 1'b0;
            r_special     <= 1'b0;
            r_special_val <= 32'd0;
        end else if (w_accept) begin
            r_is_mul      <= !funct3[2];
            r_acc         <= {32'd0, (funct3[2] ? w_mag_a : w_mag_b)};
            r_opb         <= funct3[2] ? w_mag_b : w_mag_a;
            r_neg         <= (funct3 == 3'b000) ? 1'b0 : w_neg;
            r_sel_hi      <= w_sel_hi;
            r_special     <= w_div_zero || w_ovf;
            r_special_val <= w_special_val;
        end else if (w_step) begin
            r_acc <= w_acc_nx;
        end else begin
            r_acc <= r_acc;
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: hand-computed RV32M vectors, latency, handshake and abort behaviour.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        flush;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        seen;

    int n_vec = 0;
    int n_err = 0;

    muldiv_unit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present a request and let it be sampled by the next rising edge
    task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        start  = 1'b1;
        funct3 = f;
        op_a   = a;
        op_b   = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Called one step after the accepting edge; optionally pulses a stray start at busy sample ign
    task automatic finish(input string tag, input logic [31:0] exp, input int ign);
        int          busy_n   = 0;
        int          lat      = 0;
        logic        hold_bad = 1'b0;
        logic        got      = 1'b0;
        logic [31:0] r0       = result;
        for (int k = 1; k <= 40; k++) begin
            lat = k;
            if (done) begin
                got = 1'b1;
                break;
            end
            if (busy) busy_n++;
            if (result !== r0) hold_bad = 1'b1;
            if (k == ign) begin
                start  = 1'b1;
                funct3 = 3'b000;
                op_a   = 32'd3;
                op_b   = 32'd3;
            end else if (k == ign + 1) begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        chk({tag, "/done"}, {31'd0, got}, 32'd1);
        chk({tag, "/lat"}, lat, 32'd33);
        chk({tag, "/busy_cycles"}, busy_n, 32'd32);
        chk({tag, "/busy_at_done"}, {31'd0, busy}, 32'd0);
        chk({tag, "/hold"}, {31'd0, hold_bad}, 32'd0);
        chk({tag, "/result"}, result, exp);
    endtask

    task automatic idle(input int n);
        @(posedge clk);
        #1;
        chk("idle/done_pulse", {31'd0, done}, 32'd0);
        chk("idle/busy", {31'd0, busy}, 32'd0);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic watch_no_done(input string tag);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || busy) seen = 1'b1;
        end
        chk(tag, {31'd0, seen}, 32'd0);
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        flush  = 1'b0;
        funct3 = 3'b000;
        op_a   = 32'd0;
        op_b   = 32'd0;
        #3;
        chk("reset/busy", {31'd0, busy}, 32'd0);
        chk("reset/done", {31'd0, done}, 32'd0);
        chk("reset/result", result, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        launch(3'b000, 32'd7, 32'hFFFF_FFFD);          finish("mul", 32'hFFFF_FFEB, 0); idle(2);
        launch(3'b001, 32'h8000_0000, 32'h8000_0000);  finish("mulh", 32'h4000_0000, 0); idle(1);
        launch(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);  finish("mulhu", 32'hFFFF_FFFE, 0); idle(1);
        launch(3'b010, 32'hFFFF_FFFF, 32'd2);          finish("mulhsu", 32'hFFFF_FFFF, 0); idle(1);
        launch(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);  finish("mulh_m1", 32'd0, 0); idle(1);
        launch(3'b000, 32'h0001_0000, 32'h0001_0000);  finish("mul_wrap", 32'd0, 0); idle(1);

        // Back-to-back: the second request is raised during the DONE cycle of the first
        launch(3'b100, 32'hFFFF_FFF9, 32'd2);          finish("div", 32'hFFFF_FFFD, 0);
        launch(3'b110, 32'hFFFF_FFF9, 32'd2);          finish("rem_b2b", 32'hFFFF_FFFF, 0); idle(1);

        launch(3'b100, 32'd7, 32'hFFFF_FFFE);          finish("div_neg_b", 32'hFFFF_FFFD, 0); idle(1);
        launch(3'b110, 32'd7, 32'hFFFF_FFFE);          finish("rem_neg_b", 32'd1, 0); idle(1);
        launch(3'b101, 32'd5, 32'd0);                  finish("divu_z", 32'hFFFF_FFFF, 0); idle(1);
        launch(3'b111, 32'd5, 32'd0);                  finish("remu_z", 32'd5, 0); idle(1);
        launch(3'b100, 32'hFFFF_FFF9, 32'd0);          finish("div_z", 32'hFFFF_FFFF, 0); idle(1);
        launch(3'b110, 32'hFFFF_FFF9, 32'd0);          finish("rem_z", 32'hFFFF_FFF9, 0); idle(1);
        launch(3'b100, 32'h8000_0000, 32'hFFFF_FFFF);  finish("div_ovf", 32'h8000_0000, 0); idle(1);
        launch(3'b110, 32'h8000_0000, 32'hFFFF_FFFF);  finish("rem_ovf", 32'd0, 0); idle(1);
        launch(3'b111, 32'd100, 32'd7);                finish("remu", 32'd2, 0); idle(1);

        // A stray start at busy cycle 10 must not disturb the running divide
        launch(3'b101, 32'd100, 32'd7);                finish("ign", 32'd14, 10); idle(1);

        // Flush at count 15: back to IDLE, no done, result keeps 14
        launch(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (15) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush/busy", {31'd0, busy}, 32'd0);
        chk("flush/done", {31'd0, done}, 32'd0);
        chk("flush/result", result, 32'd14);
        watch_no_done("flush/no_done");
        chk("flush/result_after", result, 32'd14);

        // Flush and start together: the request is dropped
        start  = 1'b1;
        flush  = 1'b1;
        funct3 = 3'b000;
        op_a   = 32'd2;
        op_b   = 32'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        chk("flush_start/busy", {31'd0, busy}, 32'd0);
        watch_no_done("flush_start/no_done");

        // Reset mid-operation clears outputs before any clock edge
        launch(3'b000, 32'd7, 32'hFFFF_FFFD);
        repeat (15) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        chk("rst_mid/busy", {31'd0, busy}, 32'd0);
        chk("rst_mid/done", {31'd0, done}, 32'd0);
        chk("rst_mid/result", result, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        watch_no_done("rst_mid/no_done");

        launch(3'b101, 32'd100, 32'd7);                finish("post_rst_divu", 32'd14, 0); idle(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
